lfsr_stream: RTL

LFSR_STREAM -- requirements
Module: lfsr_stream

---
 rtl/lfsr_stream.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_stream.sv
// ---------------------------------------------------------------------------
// lfsr_stream
//
// Purpose:
//   Fibonacci XNOR LFSR packaged as a valid/ready beat source. Each accepted
//   beat advances the register OUT_BITS single steps in one clock. The
//   feedback bit of every step becomes one bit of o_Data, and the oldest bit
//   lands in the MSB. A reference-seed register remembers the last loaded
//   seed, so o_LFSR_Done can pulse whenever the sequence wraps back to it.
//
// Optional feature (macro LFSR_STREAM_LOCKUP_RECOVERY_EN):
//   When defined, any all-ones state (including an all-ones seed load) is
//   replaced by DEFAULT_SEED on the same edge. o_Lockup pulses and the
//   reference seed becomes DEFAULT_SEED.
//   When undefined, o_Lockup is tied low and an all-ones seed locks the
//   register.
//
// Parameters:
//   NUM_BITS     - LFSR width, 3..32
//   OUT_BITS     - bits emitted per beat, 1..NUM_BITS
//   DEFAULT_SEED - state loaded at reset (must not be all-ones)
//
// Ports:
//   i_Clk        - clock, rising edge
//   i_Rst        - asynchronous active-high reset
//   i_Enable     - permits generation of new beats
//   i_Seed_DV    - single-cycle seed load strobe (wins over an accept)
//   i_Seed_Data  - seed value, NUM_BITS wide
//   i_Ready      - consumer accepts the current beat
//   o_Valid      - o_Data holds an unaccepted beat
//   o_Data       - emitted bits, MSB oldest
//   o_LFSR_State - current register state
//   o_LFSR_Done  - one-cycle pulse when an advance returns to the ref seed
//   o_Lockup     - one-cycle pulse on an all-ones recovery
// ---------------------------------------------------------------------------
module lfsr_stream #(
    parameter int                  NUM_BITS     = 8,
    parameter int                  OUT_BITS     = 1,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = {{(NUM_BITS-1){1'b0}}, 1'b1}
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    input  logic                i_Ready,
    output logic                o_Valid,
    output logic [OUT_BITS-1:0] o_Data,
    output logic [NUM_BITS-1:0] o_LFSR_State,
    output logic                o_LFSR_Done,
    output logic                o_Lockup
);

    // One-hot bit for XAPP052 tap number t (taps are numbered from 1).
    function automatic logic [31:0] tap(input int t);
        return 32'd1 << (t - 1);
    endfunction

    // Maximal-length tap sets from the XAPP052 table, as a bit mask.
    function automatic logic [31:0] tap_mask(input int n);
        logic [31:0] m;
        m = '0;
        case (n)
            3:  m = tap(3)  | tap(2);
            4:  m = tap(4)  | tap(3);
            5:  m = tap(5)  | tap(3);
            6:  m = tap(6)  | tap(5);
            7:  m = tap(7)  | tap(6);
            8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  m = tap(9)  | tap(5);
            10: m = tap(10) | tap(7);
            11: m = tap(11) | tap(9);
            12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
            13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
            14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
            15: m = tap(15) | tap(14);
            16: m = tap(16) | tap(15) | tap(13) | tap(4);
            17: m = tap(17) | tap(14);
            18: m = tap(18) | tap(11);
            19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
            20: m = tap(20) | tap(17);
            21: m = tap(21) | tap(19);
            22: m = tap(22) | tap(21);
            23: m = tap(23) | tap(18);
            24: m = tap(24) | tap(23) | tap(22) | tap(17);
            25: m = tap(25) | tap(22);
            26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
            27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
            28: m = tap(28) | tap(25);
            29: m = tap(29) | tap(27);
            30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
            31: m = tap(31) | tap(28);
            32: m = tap(32) | tap(22) | tap(2)  | tap(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [31:0]         TAPS32 = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAPS   = TAPS32[NUM_BITS-1:0];

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] lfsr_q, lfsr_raw, lfsr_d;
    logic [NUM_BITS-1:0] ref_q, ref_raw, ref_d;
    logic [OUT_BITS-1:0] data_q, data_d;
    logic                done_q, done_d;
    logic                advance;
    logic [NUM_BITS-1:0] walk;

    // Unrolled OUT_BITS steps. Every step shifts left and inserts the XNOR
    // feedback at bit 0. After OUT_BITS steps, the low OUT_BITS bits are
    // exactly the feedback bits, with the oldest in the highest position.
    always_comb begin
        walk = lfsr_q;
        for (int i = 0; i < OUT_BITS; i++) begin
            walk = {walk[NUM_BITS-2:0], ~(^(walk & TAPS))};
        end
    end

    // FSM next state and datapath. A seed load outranks everything else and
    // discards any beat being accepted on the same edge.
    always_comb begin
        state_d  = state_q;
        lfsr_raw = lfsr_q;
        ref_raw  = ref_q;
        data_d   = data_q;
        advance  = 1'b0;
        if (i_Seed_DV) begin
            state_d  = IDLE;
            lfsr_raw = i_Seed_Data;
            ref_raw  = i_Seed_Data;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Enable) begin
                        advance = 1'b1;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (i_Ready) begin
                        if (i_Enable) begin
                            advance = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (advance) begin
                lfsr_raw = walk;
                data_d   = walk[OUT_BITS-1:0];
            end
        end
    end

`ifdef LFSR_STREAM_LOCKUP_RECOVERY_EN
    logic lockup_q, lockup_d;

    // Any all-ones candidate state is swapped for DEFAULT_SEED on this edge.
    always_comb begin
        lfsr_d   = lfsr_raw;
        ref_d    = ref_raw;
        lockup_d = 1'b0;
        if (&lfsr_raw) begin
            lfsr_d   = DEFAULT_SEED;
            ref_d    = DEFAULT_SEED;
            lockup_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign o_Lockup = lockup_q;
`else
    assign lfsr_d   = lfsr_raw;
    assign ref_d    = ref_raw;
    assign o_Lockup = 1'b0;
`endif

    assign done_d = advance && (lfsr_d == ref_d);

    // State register and registered outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            ref_q   <= DEFAULT_SEED;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ref_q   <= ref_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_Valid      = (state_q == PRESENT);
    assign o_Data       = data_q;
    assign o_LFSR_State = lfsr_q;
    assign o_LFSR_Done  = done_q;

endmodule
